// File: rtl/xpb_lut_bank.sv
// xpb_lut_bank: run-time loadable banks of xpb reduction constants with a
// 2-stage lookup pipeline returning the selected words and their full sum.
module xpb_lut_bank #(
  parameter int WORD_W = 1024,
  parameter int IDX_W  = 5,
  parameter int NUM_CH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_load_start,
  input  logic                               i_load_valid,
  input  logic [WORD_W-1:0]                  i_load_data,
  output logic                               o_load_ready,
  output logic                               o_table_ready,
  input  logic                               i_lookup_valid,
  input  logic [NUM_CH*IDX_W-1:0]            i_lookup_idx,
  output logic                               o_lookup_ready,
  output logic                               o_out_valid,
  output logic [NUM_CH*WORD_W-1:0]           o_out_words,
  output logic [WORD_W+$clog2(NUM_CH):0]     o_out_sum
);
  localparam int SUM_W = WORD_W + $clog2(NUM_CH) + 1;
  localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]                r_state;
  logic [CH_W-1:0]           r_ch;
  logic [IDX_W-1:0]          r_idx;
  logic [WORD_W-1:0]         r_tbl [NUM_CH][1:DEPTH-1];
  logic                      r_v1;
  logic                      r_v2;
  logic [NUM_CH*WORD_W-1:0]  r_w1;
  logic [NUM_CH*WORD_W-1:0]  r_words;
  logic [SUM_W-1:0]          r_sum;
  logic [NUM_CH*WORD_W-1:0]  w_sel;
  logic [SUM_W-1:0]          w_sum;
  logic                      w_wr;
  logic                      w_last;
  logic                      w_acc;
  logic                      w_adv;

  // load_start outranks any load word or lookup presented in the same cycle
  assign w_wr   = r_state == S_LOAD && i_load_valid && !i_load_start;
  assign w_last = r_ch == CH_W'(NUM_CH - 1) && &r_idx;
  assign w_acc  = r_state == S_READY && i_lookup_valid && !i_load_start;
  assign w_adv  = r_v1 && !i_load_start;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_idx   <= IDX_W'(1);
    end else if (i_load_start) begin
      r_state <= S_LOAD;
      r_ch    <= '0;
      r_idx   <= IDX_W'(1);
    end else if (w_wr) begin
      r_state <= w_last ? S_READY : S_LOAD;
      r_idx   <= &r_idx ? IDX_W'(1) : r_idx + 1'b1;
      r_ch    <= &r_idx ? r_ch + 1'b1 : r_ch;
    end

  // storage is deliberately unreset; it is unreachable until a full load
  always_ff @(posedge clk)
    if (w_wr) r_tbl[r_ch][r_idx] <= i_load_data;

  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (i_lookup_idx[c*IDX_W +: IDX_W] != '0)
        w_sel[c*WORD_W +: WORD_W] = r_tbl[c][i_lookup_idx[c*IDX_W +: IDX_W]];
  end

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < NUM_CH; c++)
      w_sum = w_sum + SUM_W'(r_w1[c*WORD_W +: WORD_W]);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_w1    <= '0;
      r_words <= '0;
      r_sum   <= '0;
    end else begin
      r_v1 <= w_acc;
      r_v2 <= w_adv;
      if (w_acc) r_w1 <= w_sel;
      if (w_adv) begin
        r_words <= r_w1;
        r_sum   <= w_sum;
      end
    end

  assign o_load_ready   = r_state == S_LOAD;
  assign o_table_ready  = r_state == S_READY;
  assign o_lookup_ready = r_state == S_READY;
  assign o_out_valid    = r_v2;
  assign o_out_words    = r_words;
  assign o_out_sum      = r_sum;
endmodule

// File: tb/tb_xpb_lut_bank.sv
// tb_xpb_lut_bank: directed checks of loading, lookups, restart and reset on a
// small 2-channel, 4-entry, 16-bit configuration.
module tb_xpb_lut_bank;
  localparam int WW = 16;
  localparam int IW = 2;
  localparam int NC = 2;
  localparam int SW = 18;

  logic          clk;
  logic          rst_n;
  logic          i_load_start;
  logic          i_load_valid;
  logic [WW-1:0] i_load_data;
  logic          o_load_ready;
  logic          o_table_ready;
  logic          i_lookup_valid;
  logic [NC*IW-1:0] i_lookup_idx;
  logic          o_lookup_ready;
  logic          o_out_valid;
  logic [NC*WW-1:0] o_out_words;
  logic [SW-1:0] o_out_sum;

  int n_chk = 0;
  int n_fail = 0;

  xpb_lut_bank #(.WORD_W(WW), .IDX_W(IW), .NUM_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_load_start(i_load_start), .i_load_valid(i_load_valid), .i_load_data(i_load_data),
    .o_load_ready(o_load_ready), .o_table_ready(o_table_ready),
    .i_lookup_valid(i_lookup_valid), .i_lookup_idx(i_lookup_idx),
    .o_lookup_ready(o_lookup_ready), .o_out_valid(o_out_valid),
    .o_out_words(o_out_words), .o_out_sum(o_out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
  endtask

  task automatic load6(input logic [15:0] d [6], input bit gap);
    for (int i = 0; i < 6; i++) begin
      if (gap) step();
      i_load_valid = 1'b1;
      i_load_data  = d[i];
      step();
      i_load_valid = 1'b0;
      if (i == 4) chk("table_ready_before_last", o_table_ready, 0);
    end
    chk("table_ready_after_last", o_table_ready, 1);
    chk("lookup_ready_after_load", o_lookup_ready, 1);
    chk("load_ready_after_load", o_load_ready, 0);
  endtask

  task automatic lookup(input string tag, input logic [3:0] idx, input logic [31:0] ew,
                        input logic [17:0] es);
    i_lookup_valid = 1'b1;
    i_lookup_idx   = idx;
    step();
    i_lookup_valid = 1'b0;
    chk({tag, "_valid_stage1"}, o_out_valid, 0);
    step();
    chk({tag, "_valid"}, o_out_valid, 1);
    chk({tag, "_words"}, o_out_words, ew);
    chk({tag, "_sum"}, o_out_sum, es);
    step();
    chk({tag, "_valid_drop"}, o_out_valid, 0);
    chk({tag, "_words_hold"}, o_out_words, ew);
  endtask

  task automatic stream(input string tag);
    logic [3:0]  l  [4] = '{4'h5, 4'hA, 4'hF, 4'h0};
    logic [17:0] sl [4] = '{18'h111, 18'h222, 18'h333, 18'h000};
    for (int j = 0; j < 5; j++) begin
      i_lookup_valid = j < 4;
      if (j < 4) i_lookup_idx = l[j];
      step();
      if (j >= 1) begin
        chk($sformatf("%s_valid_%0d", tag, j - 1), o_out_valid, 1);
        chk($sformatf("%s_sum_%0d", tag, j - 1), o_out_sum, sl[j-1]);
      end
    end
    i_lookup_valid = 1'b0;
    step();
    chk({tag, "_valid_end"}, o_out_valid, 0);
  endtask

  logic [15:0] base [6] = '{16'h0011, 16'h0022, 16'h0033, 16'h0100, 16'h0200, 16'h0300};
  logic [15:0] ones [6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
  logic [15:0] nw   [6] = '{16'h0001, 16'h0002, 16'h0003, 16'h0010, 16'h0020, 16'h0030};

  initial begin
    rst_n = 1'b0;
    i_load_start = 1'b0;
    i_load_valid = 1'b0;
    i_load_data = '0;
    i_lookup_valid = 1'b0;
    i_lookup_idx = '0;
    #2;
    chk("rst_load_ready", o_load_ready, 0);
    chk("rst_table_ready", o_table_ready, 0);
    chk("rst_lookup_ready", o_lookup_ready, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_words", o_out_words, 0);
    chk("rst_out_sum", o_out_sum, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_lookup_ready", o_lookup_ready, 0);
    chk("idle_load_ready", o_load_ready, 0);

    start();
    chk("load_ready_in_load", o_load_ready, 1);
    load6(base, 1'b0);
    lookup("basic", 4'b10_11, 32'h0200_0033, 18'h00233);
    lookup("idx00", 4'b00_00, 32'h0000_0000, 18'h00000);
    lookup("idx01", 4'b00_01, 32'h0000_0011, 18'h00011);
    stream("stream1");

    start();
    load6(base, 1'b1);
    stream("stream2");

    start();
    load6(ones, 1'b0);
    lookup("overflow", 4'b11_11, 32'hFFFF_FFFF, 18'h1FFFE);

    // lookup accepted, then load_start the next cycle squashes it
    i_lookup_valid = 1'b1;
    i_lookup_idx = 4'b01_01;
    step();
    i_lookup_valid = 1'b0;
    i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
    chk("restart_out_valid_a", o_out_valid, 0);
    chk("restart_table_ready", o_table_ready, 0);
    chk("restart_lookup_ready", o_lookup_ready, 0);
    step();
    chk("restart_out_valid_b", o_out_valid, 0);

    i_load_start = 1'b1;
    i_load_valid = 1'b1;
    i_load_data = 16'hDEAD;
    step();
    i_load_start = 1'b0;
    i_load_valid = 1'b0;
    load6(nw, 1'b0);
    lookup("reload_11", 4'b01_01, 32'h0010_0001, 18'h00011);
    lookup("reload_32", 4'b11_10, 32'h0030_0002, 18'h00032);

    start();
    for (int i = 0; i < 3; i++) begin
      i_load_valid = 1'b1;
      i_load_data = base[i];
      step();
    end
    i_load_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_load_ready", o_load_ready, 0);
    chk("arst_table_ready", o_table_ready, 0);
    chk("arst_lookup_ready", o_lookup_ready, 0);
    chk("arst_out_valid", o_out_valid, 0);
    chk("arst_out_words", o_out_words, 0);
    chk("arst_out_sum", o_out_sum, 0);
    step();
    rst_n = 1'b1;
    i_lookup_valid = 1'b1;
    i_lookup_idx = 4'b01_01;
    step();
    chk("post_rst_lookup_ready", o_lookup_ready, 0);
    step();
    i_lookup_valid = 1'b0;
    chk("post_rst_out_valid", o_out_valid, 0);
    step();
    chk("post_rst_out_valid_b", o_out_valid, 0);
    start();
    load6(base, 1'b0);
    lookup("post_rst", 4'b10_11, 32'h0200_0033, 18'h00233);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
